// File: rtl/sum_arbiter.sv
// Round-robin arbiter sharing one 8-bit summation unit among NREQ requesters:
// grants, streams the winner's operands, waits for done and returns a tagged result.
module sum_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 16,
    parameter int MAXLEN  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*8-1:0]       req_data,
    output logic [NREQ-1:0]         ack,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         pop,
    output logic                    go_l,
    output logic [7:0]              inA,
    input  logic                    done,
    input  logic [7:0]              sum,
    output logic                    res_valid,
    output logic [$clog2(NREQ)-1:0] res_id,
    output logic [7:0]              res_sum,
    output logic [1:0]              res_err,
    output logic                    busy
);
    localparam int DATA_W = 8;
    localparam int IDW    = $clog2(NREQ);
    localparam int LENW   = $clog2(MAXLEN + 1);
    localparam int TW     = $clog2(TIMEOUT + 1);
    localparam logic [NREQ-1:0] ONE = NREQ'(1);

    typedef enum logic [2:0] {IDLE, START, STREAM, WAIT, RESP} state_t;

    state_t             state, state_n;
    logic [NREQ-1:0]    gnt_n, pop_n, ack_n;
    logic               go_l_n, res_valid_n, busy_n, trunc, trunc_n;
    logic [DATA_W-1:0]  ina_n, res_sum_n, cur;
    logic [1:0]         res_err_n;
    logic [IDW-1:0]     res_id_n, rr, rr_n, gidx, gidx_n, pick;
    logic [LENW-1:0]    len, len_n;
    logic [TW-1:0]      tcnt, tcnt_n;
    logic [DATA_W-1:0]  opnd [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_opnd
        assign opnd[i] = req_data[i*DATA_W +: DATA_W];
    end

    assign cur = opnd[gidx];

    // first requester at or above the pointer, wrapping at NREQ
    function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                               input logic [IDW-1:0]  p);
        logic [IDW-1:0] sel;
        logic           found;
        int             idx;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(p) + k) % NREQ;
            if (!found && r[idx]) begin
                found = 1'b1;
                sel   = IDW'(idx);
            end
        end
        return sel;
    endfunction

    assign pick = rr_pick(req, rr);

    // pop is issued one cycle ahead of inA: the requester's operand is sampled
    // in the same cycle pop is high, and it advances on the following edge
    always_comb begin
        state_n     = state;
        gnt_n       = gnt;
        pop_n       = '0;
        ack_n       = '0;
        go_l_n      = 1'b1;
        ina_n       = '0;
        res_valid_n = 1'b0;
        res_id_n    = res_id;
        res_sum_n   = res_sum;
        res_err_n   = res_err;
        rr_n        = rr;
        gidx_n      = gidx;
        len_n       = len;
        tcnt_n      = tcnt;
        trunc_n     = trunc;
        case (state)
            IDLE: begin
                if (req != '0) begin
                    gidx_n  = pick;
                    gnt_n   = ONE << pick;
                    pop_n   = (MAXLEN > 1) ? (ONE << pick) : '0;
                    go_l_n  = 1'b0;
                    len_n   = '0;
                    tcnt_n  = '0;
                    trunc_n = 1'b0;
                    state_n = START;
                end
            end
            START, STREAM: begin
                len_n = len + 1'b1;
                if (pop != '0) begin
                    ina_n = cur;
                    if (cur == '0) begin
                        state_n = WAIT;
                    end else begin
                        state_n = STREAM;
                        if (len + 1'b1 < LENW'(MAXLEN - 1))
                            pop_n = gnt;
                    end
                end else begin
                    // length limit hit: unconsumed operand replaced by a terminator
                    ina_n   = '0;
                    trunc_n = (cur != '0);
                    state_n = WAIT;
                end
            end
            WAIT: begin
                tcnt_n = tcnt + 1'b1;
                if (done) begin
                    res_sum_n = sum;
                    res_err_n = trunc ? 2'b01 : 2'b00;
                    state_n   = RESP;
                end else if (tcnt + 1'b1 >= TW'(TIMEOUT)) begin
                    res_sum_n = '0;
                    res_err_n = 2'b10;
                    state_n   = RESP;
                end
                if (state_n == RESP) begin
                    res_valid_n = 1'b1;
                    res_id_n    = gidx;
                    ack_n       = gnt;
                end
            end
            RESP: begin
                gnt_n   = '0;
                rr_n    = (gidx == IDW'(NREQ - 1)) ? '0 : gidx + 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            pop       <= '0;
            ack       <= '0;
            go_l      <= 1'b1;
            inA       <= '0;
            res_valid <= 1'b0;
            res_id    <= '0;
            res_sum   <= '0;
            res_err   <= '0;
            busy      <= 1'b0;
            rr        <= '0;
            gidx      <= '0;
            len       <= '0;
            tcnt      <= '0;
            trunc     <= 1'b0;
        end else begin
            state     <= state_n;
            gnt       <= gnt_n;
            pop       <= pop_n;
            ack       <= ack_n;
            go_l      <= go_l_n;
            inA       <= ina_n;
            res_valid <= res_valid_n;
            res_id    <= res_id_n;
            res_sum   <= res_sum_n;
            res_err   <= res_err_n;
            busy      <= busy_n;
            rr        <= rr_n;
            gidx      <= gidx_n;
            len       <= len_n;
            tcnt      <= tcnt_n;
            trunc     <= trunc_n;
        end
    end

endmodule
